// File: rtl/hdmi_hb_pkg.sv
// Shared types and constants for the HDMI TX link heartbeat generator.
package hdmi_hb_pkg;

    localparam int unsigned LOSS_W = 8;
    localparam int unsigned TOG_W  = 8;

    typedef enum logic [1:0] {
        HB_DOWN = 2'd0,
        HB_UP   = 2'd1,
        HB_LOST = 2'd2
    } hb_state_e;

    // Fast half-period: floor(period/div), never below one cycle.
    function automatic int unsigned calc_fast_per(input int unsigned period,
                                                  input int unsigned div);
        int unsigned q;
        q = period / div;
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/hdmi_hb_mc_if.sv
// Link-status sideband stream, one beat lane per channel.
interface hdmi_hb_mc_if #(
    parameter int unsigned NUM_CH = 2
);
    logic [2*NUM_CH-1:0] tdata;
    logic [NUM_CH-1:0]   tvalid;
    logic [NUM_CH-1:0]   tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/hdmi_hb_ch.sv
// One heartbeat channel: link-ready capture, DOWN/UP/LOST FSM, blink counters, loss counter.
module hdmi_hb_ch
    import hdmi_hb_pkg::*;
#(
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned HB_PERIOD = 10_000_000,
    parameter int unsigned FAST_DIV  = 4,
    parameter int unsigned LOST_HOLD = 8
) (
    input  logic              link_clk,
    input  logic              link_rst,
    input  logic              sb_rdy,
    input  logic              sb_tvalid,
    input  logic              sb_tready,
    output logic              hdmi_hb,
    output logic              link_up,
    output logic [LOSS_W-1:0] loss_cnt
);

    localparam int unsigned FAST_PER = calc_fast_per(HB_PERIOD, FAST_DIV);

    localparam logic [1:0] S_DOWN = HB_DOWN;
    localparam logic [1:0] S_UP   = HB_UP;
    localparam logic [1:0] S_LOST = HB_LOST;

    localparam logic [CNT_W-1:0] UP_LAST   = CNT_W'(HB_PERIOD - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_PER - 1);
    localparam logic [TOG_W-1:0] TOG_LAST  = TOG_W'(LOST_HOLD - 1);

    logic              rdy_q;
    logic [1:0]        state, nxt_state;
    logic [CNT_W-1:0]  cnt, nxt_cnt;
    logic [TOG_W-1:0]  tog, nxt_tog;
    logic              nxt_hb;
    logic              nxt_link_up;
    logic [LOSS_W-1:0] nxt_loss;

    // State and datapath registers; reset wins over any sideband beat.
    always_ff @(posedge link_clk) begin
        if (link_rst) begin
            rdy_q    <= 1'b0;
            state    <= S_DOWN;
            cnt      <= '0;
            tog      <= '0;
            hdmi_hb  <= 1'b0;
            link_up  <= 1'b0;
            loss_cnt <= '0;
        end else begin
            if (sb_tvalid && sb_tready) begin
                rdy_q <= sb_rdy;
            end
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            tog      <= nxt_tog;
            hdmi_hb  <= nxt_hb;
            link_up  <= nxt_link_up;
            loss_cnt <= nxt_loss;
        end
    end

    // Next-state and blink logic; a returning link always beats LOST expiry.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_tog   = tog;
        nxt_hb    = hdmi_hb;
        nxt_loss  = loss_cnt;
        case (state)
            S_DOWN: begin
                nxt_hb  = 1'b0;
                nxt_cnt = '0;
                if (rdy_q) begin
                    nxt_state = S_UP;
                end
            end
            S_UP: begin
                if (!rdy_q) begin
                    nxt_state = S_LOST;
                    nxt_cnt   = '0;
                    nxt_hb    = 1'b1;
                    nxt_tog   = '0;
                    if (loss_cnt != '1) begin
                        nxt_loss = loss_cnt + LOSS_W'(1);
                    end
                end else if (cnt == UP_LAST) begin
                    nxt_cnt = '0;
                    nxt_hb  = ~hdmi_hb;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            S_LOST: begin
                if (rdy_q) begin
                    nxt_state = S_UP;
                    nxt_cnt   = '0;
                    nxt_hb    = 1'b0;
                end else if (cnt == FAST_LAST) begin
                    nxt_cnt = '0;
                    nxt_tog = tog + TOG_W'(1);
                    if (tog == TOG_LAST) begin
                        nxt_state = S_DOWN;
                        nxt_hb    = 1'b0;
                    end else begin
                        nxt_hb = ~hdmi_hb;
                    end
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            default: begin
                nxt_state = S_DOWN;
                nxt_cnt   = '0;
                nxt_hb    = 1'b0;
            end
        endcase
        nxt_link_up = (nxt_state == S_UP);
    end

endmodule

// File: rtl/hdmi_hb_mc.sv
// Multi-channel link heartbeat generator: slices the sideband and replicates the channel.
module hdmi_hb_mc
    import hdmi_hb_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned HB_PERIOD = 10_000_000,
    parameter int unsigned FAST_DIV  = 4,
    parameter int unsigned LOST_HOLD = 8
) (
    input  logic                     link_clk,
    input  logic                     link_rst,
    hdmi_hb_mc_if.slave              status_sb,
    output logic [NUM_CH-1:0]        hdmi_hb,
    output logic [NUM_CH-1:0]        link_up,
    output logic [LOSS_W*NUM_CH-1:0] loss_cnt
);

    logic [NUM_CH-1:0] rsvd_unused;

    // Sideband is always accepted outside reset; registered so reset drops beats cleanly.
    always_ff @(posedge link_clk) begin
        if (link_rst) begin
            status_sb.tready <= '0;
        end else begin
            status_sb.tready <= '1;
        end
    end

    // One independent channel per lane.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign rsvd_unused[i] = status_sb.tdata[2*i+1];

        hdmi_hb_ch #(
            .CNT_W     (CNT_W),
            .HB_PERIOD (HB_PERIOD),
            .FAST_DIV  (FAST_DIV),
            .LOST_HOLD (LOST_HOLD)
        ) u_ch (
            .link_clk  (link_clk),
            .link_rst  (link_rst),
            .sb_rdy    (status_sb.tdata[2*i]),
            .sb_tvalid (status_sb.tvalid[i]),
            .sb_tready (status_sb.tready[i]),
            .hdmi_hb   (hdmi_hb[i]),
            .link_up   (link_up[i]),
            .loss_cnt  (loss_cnt[LOSS_W*i +: LOSS_W])
        );
    end

endmodule

// File: tb/tb_hdmi_hb_mc.sv
// Directed bench for hdmi_hb_mc: NUM_CH=2, HB_PERIOD=8, FAST_PER=2, LOST_HOLD=4.
module tb_hdmi_hb_mc;

    localparam int unsigned NUM_CH = 2;

    logic        link_clk = 1'b0;
    logic        link_rst;
    logic [1:0]  hdmi_hb;
    logic [1:0]  link_up;
    logic [15:0] loss_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    logic lost_exp [1:8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    hdmi_hb_mc_if #(.NUM_CH(NUM_CH)) status_sb ();

    hdmi_hb_mc #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (8),
        .HB_PERIOD (8),
        .FAST_DIV  (4),
        .LOST_HOLD (4)
    ) dut (
        .link_clk  (link_clk),
        .link_rst  (link_rst),
        .status_sb (status_sb),
        .hdmi_hb   (hdmi_hb),
        .link_up   (link_up),
        .loss_cnt  (loss_cnt)
    );

    always #5 link_clk = ~link_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge link_clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [3:0] d);
        status_sb.tvalid = v;
        status_sb.tdata  = d;
    endtask

    initial begin
        // Reset with valid ready-beats on both channels
        link_rst = 1'b1;
        drive(2'b11, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hb",    32'(hdmi_hb),          32'h0);
            chk("rst_up",    32'(link_up),          32'h0);
            chk("rst_loss",  32'(loss_cnt),         32'h0);
            chk("rst_tready", 32'(status_sb.tready), 32'h0);
        end
        link_rst = 1'b0;
        tick();
        chk("rel_tready", 32'(status_sb.tready), 32'h3);
        drive(2'b00, 4'b0000);
        tick();
        chk("rel_beat_dropped", 32'(link_up), 32'h0);

        // Link up on ch0: beat at k
        drive(2'b01, 4'b0001);
        tick();
        chk("up_k_lu", 32'(link_up), 32'h0);
        drive(2'b00, 4'b0001);
        tick();
        chk("up_k1_lu", 32'(link_up), 32'h1);
        chk("up_k1_hb", 32'(hdmi_hb), 32'h0);
        repeat (7) tick();
        chk("up_k8_hb", 32'(hdmi_hb), 32'h0);
        tick();
        chk("up_k9_hb", 32'(hdmi_hb), 32'h1);
        drive(2'b01, 4'b0001);
        tick();
        drive(2'b00, 4'b0001);
        repeat (6) tick();
        chk("up_k16_hb", 32'(hdmi_hb), 32'h1);
        tick();
        chk("up_k17_hb", 32'(hdmi_hb), 32'h0);
        chk("up_k17_lu", 32'(link_up), 32'h1);

        // Link loss on ch0: LOST at e
        drive(2'b01, 4'b0000);
        tick();
        drive(2'b00, 4'b0000);
        tick();
        chk("loss_e_lu",   32'(link_up),  32'h0);
        chk("loss_e_hb",   32'(hdmi_hb),  32'h1);
        chk("loss_e_cnt",  32'(loss_cnt), 32'h0001);
        for (int n = 1; n <= 8; n++) begin
            tick();
            chk("loss_blink_hb", 32'(hdmi_hb), 32'(lost_exp[n]));
        end
        tick();
        chk("loss_down_hb", 32'(hdmi_hb), 32'h0);
        chk("loss_down_lu", 32'(link_up), 32'h0);

        // Recovery racing LOST expiry
        drive(2'b01, 4'b0001);
        tick();
        drive(2'b00, 4'b0001);
        tick();
        tick();
        tick();
        chk("race_pre_lu", 32'(link_up), 32'h1);
        drive(2'b01, 4'b0000);
        tick();
        drive(2'b00, 4'b0000);
        tick();
        chk("race_e_cnt", 32'(loss_cnt), 32'h0002);
        chk("race_e_hb",  32'(hdmi_hb),  32'h1);
        repeat (6) tick();
        drive(2'b01, 4'b0001);
        tick();
        chk("race_e7_hb", 32'(hdmi_hb), 32'h0);
        chk("race_e7_lu", 32'(link_up), 32'h0);
        drive(2'b00, 4'b0001);
        tick();
        chk("race_e8_lu", 32'(link_up), 32'h1);
        chk("race_e8_hb", 32'(hdmi_hb), 32'h0);
        tick();
        chk("race_e9_lu", 32'(link_up), 32'h1);

        // Saturation on ch1
        for (int i = 0; i < 255; i++) begin
            drive(2'b10, 4'b0101);
            tick();
            tick();
            drive(2'b10, 4'b0001);
            tick();
            tick();
        end
        chk("sat_255", 32'(loss_cnt), 32'hFF02);
        for (int i = 0; i < 5; i++) begin
            drive(2'b10, 4'b0101);
            tick();
            tick();
            drive(2'b10, 4'b0001);
            tick();
            tick();
        end
        drive(2'b00, 4'b0001);
        chk("sat_held", 32'(loss_cnt), 32'hFF02);
        chk("sat_ch0_up", 32'(link_up[0]), 32'h1);

        // Reset in the middle of ch0 fast blink
        drive(2'b01, 4'b0000);
        tick();
        drive(2'b00, 4'b0000);
        tick();
        chk("mid_loss0", 32'(loss_cnt[7:0]), 32'h03);
        tick();
        chk("mid_hb0", 32'(hdmi_hb[0]), 32'h1);
        link_rst = 1'b1;
        tick();
        chk("mid_rst_hb",     32'(hdmi_hb),          32'h0);
        chk("mid_rst_lu",     32'(link_up),          32'h0);
        chk("mid_rst_loss",   32'(loss_cnt),         32'h0);
        chk("mid_rst_tready", 32'(status_sb.tready), 32'h0);
        link_rst = 1'b0;
        tick();
        chk("mid_rel_tready", 32'(status_sb.tready), 32'h3);
        drive(2'b01, 4'b0001);
        tick();
        drive(2'b00, 4'b0001);
        tick();
        chk("restart_lu",   32'(link_up),  32'h1);
        chk("restart_hb",   32'(hdmi_hb),  32'h0);
        chk("restart_loss", 32'(loss_cnt), 32'h0);
        drive(2'b01, 4'b0000);
        tick();
        drive(2'b00, 4'b0000);
        tick();
        chk("restart_loss1", 32'(loss_cnt), 32'h0001);
        chk("restart_hb1",   32'(hdmi_hb),  32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
